// File: rtl/tap_read_interconnect_mc.sv
// tap_read_interconnect_mc
// Collects read data from the DMI and from NUM_STB strobe channels (status and
// data per channel) into one-entry holding buffers that the TAP reads by IR
// address. A registered round-robin scanner advertises an address whose buffer
// is full, so the TAP can poll without walking the whole address space.
//
// Source index order: 0 = DMI, 1+2k = STBk status, 2+2k = STBk data.
// Source i (i > 0) lives at STB_BASE_ADDR + i - 1.
//
// Optional feature macro: TAP_READ_INTC_OCC_EN
//   defined   : OCC_ADDR returns the per-source full flags (always valid,
//               reading it consumes nothing)
//   undefined : OCC_ADDR is unmapped

module tap_read_interconnect_mc #(
    parameter int                    NUM_STB          = 2,
    parameter int                    IRLENGTH         = 5,
    parameter int                    READ_WIDTH       = 41,
    parameter int                    DMI_WIDTH        = 41,
    parameter int                    STB_STATUS_WIDTH = 8,
    parameter int                    STB_DATA_WIDTH   = 32,
    parameter logic [IRLENGTH-1:0]   DMI_ADDR         = 5'h11,
    parameter logic [IRLENGTH-1:0]   STB_BASE_ADDR    = 5'h12,
    parameter logic [IRLENGTH-1:0]   OCC_ADDR         = 5'h1F
) (
    input  logic                                 CLK_I,
    input  logic                                 RST_I,
    input  logic [IRLENGTH-1:0]                  READ_ADDRESS_I,
    output logic [READ_WIDTH-1:0]                READ_DATA_O,
    output logic                                 READ_VALID_O,
    input  logic                                 READ_READY_I,
    output logic [IRLENGTH-1:0]                  VALID_ADDRESS_O,
    output logic                                 VALID_ANY_O,
    output logic                                 DMI_READ_READY_O,
    input  logic                                 DMI_READ_VALID_I,
    input  logic [DMI_WIDTH-1:0]                 DMI_READ_DATA_I,
    output logic [NUM_STB-1:0]                   STB_STATUS_READY_O,
    input  logic [NUM_STB-1:0]                   STB_STATUS_VALID_I,
    input  logic [NUM_STB*STB_STATUS_WIDTH-1:0]  STB_STATUS_I,
    output logic [NUM_STB-1:0]                   STB_DATA_READY_O,
    input  logic [NUM_STB-1:0]                   STB_DATA_VALID_I,
    input  logic [NUM_STB*STB_DATA_WIDTH-1:0]    STB_DATA_I
);

    localparam int NSRC  = 1 + 2 * NUM_STB;
    localparam int PTR_W = $clog2(NSRC);
    localparam int TOP_ADDR = int'(STB_BASE_ADDR) + 2 * NUM_STB - 1;

    // Elaboration-time parameter sanity checks
    if (NUM_STB < 1 || NUM_STB > 6) begin : g_chk_num_stb
        $error("NUM_STB must be in 1..6");
    end
    if (DMI_WIDTH > READ_WIDTH) begin : g_chk_dmi_width
        $error("DMI_WIDTH must not exceed READ_WIDTH");
    end
    if (STB_STATUS_WIDTH > READ_WIDTH || STB_DATA_WIDTH > READ_WIDTH) begin : g_chk_stb_width
        $error("STB widths must not exceed READ_WIDTH");
    end
    if (TOP_ADDR >= int'(OCC_ADDR)) begin : g_chk_addr_map
        $error("highest STB address must be below OCC_ADDR");
    end
    if (NSRC > READ_WIDTH) begin : g_chk_occ_width
        $error("occupancy word does not fit READ_WIDTH");
    end

    // TAP address of source i
    function automatic logic [IRLENGTH-1:0] src_addr(input int i);
        if (i == 0) return DMI_ADDR;
        return STB_BASE_ADDR + IRLENGTH'(i - 1);
    endfunction

    logic [NSRC-1:0]       src_valid;
    logic [READ_WIDTH-1:0] src_data [NSRC];

    logic [NSRC-1:0]       full_q, full_d;
    logic [NSRC-1:0]       ready_q, ready_d;
    logic [READ_WIDTH-1:0] data_q [NSRC];
    logic [READ_WIDTH-1:0] data_d [NSRC];

    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic                  valid_any_q, valid_any_d;
    logic [IRLENGTH-1:0]   valid_addr_q, valid_addr_d;

    logic                  sel_hit;
    logic [PTR_W-1:0]      sel_idx;
    logic                  read_valid;
    logic [READ_WIDTH-1:0] read_data;
    logic                  consume;

    // Flatten the DMI and per-channel sources into one zero-extended source list
    always_comb begin
        src_valid    = '0;
        src_valid[0] = DMI_READ_VALID_I;
        src_data[0]  = READ_WIDTH'(DMI_READ_DATA_I);
        for (int k = 0; k < NUM_STB; k++) begin
            src_valid[1+2*k] = STB_STATUS_VALID_I[k];
            src_data[1+2*k]  = READ_WIDTH'(STB_STATUS_I[k*STB_STATUS_WIDTH +: STB_STATUS_WIDTH]);
            src_valid[2+2*k] = STB_DATA_VALID_I[k];
            src_data[2+2*k]  = READ_WIDTH'(STB_DATA_I[k*STB_DATA_WIDTH +: STB_DATA_WIDTH]);
        end
    end

    // Address decode and combinational read mux
    always_comb begin
        sel_hit = 1'b0;
        sel_idx = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (READ_ADDRESS_I == src_addr(i)) begin
                sel_hit = 1'b1;
                sel_idx = PTR_W'(i);
            end
        end
        read_valid = sel_hit && full_q[sel_idx];
        read_data  = sel_hit ? data_q[sel_idx] : '0;
`ifdef TAP_READ_INTC_OCC_EN
        if (READ_ADDRESS_I == OCC_ADDR) begin
            read_valid = 1'b1;
            read_data  = READ_WIDTH'(full_q);
        end
`endif
        // sel_hit keeps the occupancy word from ever clearing a buffer
        consume = sel_hit && read_valid && READ_READY_I;
    end

    // Buffer fill/clear; ready is simply the registered inverse of next-full
    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            full_d[i] = full_q[i];
            data_d[i] = data_q[i];
            if (consume && (sel_idx == PTR_W'(i))) begin
                full_d[i] = 1'b0;
                data_d[i] = '0;
            end
            if (src_valid[i] && ready_q[i]) begin
                full_d[i] = 1'b1;
                data_d[i] = src_data[i];
            end
        end
        ready_d = ~full_d;
    end

    // Round-robin scanner: hold on a full, unconsumed buffer, else search forward
    always_comb begin
        logic found;
        int   idx;
        found = 1'b0;
        idx   = 0;
        ptr_d = ptr_q;
        if (!(full_q[ptr_q] && !(consume && (sel_idx == ptr_q)))) begin
            // Offset NSRC wraps back to cur itself, covering a same-cycle refill
            for (int off = 1; off <= NSRC; off++) begin
                idx = int'(ptr_q) + off;
                if (idx >= NSRC) idx = idx - NSRC;
                if (!found && full_d[idx]) begin
                    found = 1'b1;
                    ptr_d = PTR_W'(idx);
                end
            end
        end
        valid_any_d  = full_d[ptr_d];
        valid_addr_d = full_d[ptr_d] ? src_addr(int'(ptr_d)) : '0;
    end

    // State registers
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            full_q       <= '0;
            ready_q      <= '0;
            ptr_q        <= '0;
            valid_any_q  <= 1'b0;
            valid_addr_q <= '0;
            for (int i = 0; i < NSRC; i++) data_q[i] <= '0;
        end else begin
            full_q       <= full_d;
            ready_q      <= ready_d;
            ptr_q        <= ptr_d;
            valid_any_q  <= valid_any_d;
            valid_addr_q <= valid_addr_d;
            for (int i = 0; i < NSRC; i++) data_q[i] <= data_d[i];
        end
    end

    // Output mapping of the flat ready vector back onto the per-source ports
    always_comb begin
        DMI_READ_READY_O = ready_q[0];
        for (int k = 0; k < NUM_STB; k++) begin
            STB_STATUS_READY_O[k] = ready_q[1+2*k];
            STB_DATA_READY_O[k]   = ready_q[2+2*k];
        end
    end

    assign READ_VALID_O    = read_valid;
    assign READ_DATA_O     = read_data;
    assign VALID_ANY_O     = valid_any_q;
    assign VALID_ADDRESS_O = valid_addr_q;

endmodule

// File: tb/tb_tap_read_interconnect_mc.sv
// Self-checking bench for tap_read_interconnect_mc (default parameters).
module tb_tap_read_interconnect_mc;

    logic        clk;
    logic        rst;
    logic [4:0]  read_address;
    logic [40:0] read_data;
    logic        read_valid;
    logic        read_ready;
    logic [4:0]  valid_address;
    logic        valid_any;
    logic        dmi_ready;
    logic        dmi_valid;
    logic [40:0] dmi_data;
    logic [1:0]  stb_status_ready;
    logic [1:0]  stb_status_valid;
    logic [15:0] stb_status;
    logic [1:0]  stb_data_ready;
    logic [1:0]  stb_data_valid;
    logic [63:0] stb_data;

    typedef struct {
        logic [4:0]  addr;
        logic [40:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    tap_read_interconnect_mc dut (
        .CLK_I              (clk),
        .RST_I              (rst),
        .READ_ADDRESS_I     (read_address),
        .READ_DATA_O        (read_data),
        .READ_VALID_O       (read_valid),
        .READ_READY_I       (read_ready),
        .VALID_ADDRESS_O    (valid_address),
        .VALID_ANY_O        (valid_any),
        .DMI_READ_READY_O   (dmi_ready),
        .DMI_READ_VALID_I   (dmi_valid),
        .DMI_READ_DATA_I    (dmi_data),
        .STB_STATUS_READY_O (stb_status_ready),
        .STB_STATUS_VALID_I (stb_status_valid),
        .STB_STATUS_I       (stb_status),
        .STB_DATA_READY_O   (stb_data_ready),
        .STB_DATA_VALID_I   (stb_data_valid),
        .STB_DATA_I         (stb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        read_address = 5'h11;
        @(negedge clk);
        n_total++;
        if ({dmi_ready, stb_status_ready, stb_data_ready} !== 5'b0)
            $display("FAIL reset_ready: got %b want 00000", {dmi_ready, stb_status_ready, stb_data_ready});
        else n_pass++;
        n_total++;
        if ({valid_any, valid_address, read_valid, read_data} !== 48'h0)
            $display("FAIL reset_outputs: any=%b addr=%h rv=%b rd=%h want all 0", valid_any, valid_address, read_valid, read_data);
        else n_pass++;
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_total++;
        if (dmi_ready !== 1'b0) $display("FAIL ready_before_edge: got %b want 0", dmi_ready);
        else n_pass++;
        tick();
        @(negedge clk);
        n_total++;
        if ({dmi_ready, stb_status_ready, stb_data_ready} !== 5'b11111)
            $display("FAIL ready_after_release: got %b want 11111", {dmi_ready, stb_status_ready, stb_data_ready});
        else n_pass++;
        n_total++;
        if (valid_any !== 1'b0 || read_valid !== 1'b0)
            $display("FAIL idle_valid: any=%b rv=%b want 0 0", valid_any, read_valid);
        else n_pass++;
    endtask

    task automatic test_dmi();
        exp_t e;
        tick();
        dmi_valid = 1'b1;
        dmi_data  = 41'h1_2345_6789;
        exp_q.push_back('{addr: 5'h11, data: 41'h1_2345_6789});
        tick();
        dmi_valid = 1'b0;
        dmi_data  = '0;
        e = exp_q.pop_front();
        read_address = e.addr;
        @(negedge clk);
        n_total++;
        if (dmi_ready !== 1'b0) $display("FAIL dmi_ready_drop: got %b want 0", dmi_ready);
        else n_pass++;
        n_total++;
        if (read_valid !== 1'b1 || read_data !== e.data)
            $display("FAIL dmi_read: rv=%b rd=%h want 1 %h", read_valid, read_data, e.data);
        else n_pass++;
        n_total++;
        if (valid_any !== 1'b1 || valid_address !== e.addr)
            $display("FAIL dmi_advert: any=%b addr=%h want 1 %h", valid_any, valid_address, e.addr);
        else n_pass++;
        tick();
        read_ready = 1'b1;
        tick();
        read_ready = 1'b0;
        @(negedge clk);
        n_total++;
        if (dmi_ready !== 1'b1 || valid_any !== 1'b0 || read_valid !== 1'b0)
            $display("FAIL dmi_consume: ready=%b any=%b rv=%b want 1 0 0", dmi_ready, valid_any, read_valid);
        else n_pass++;
    endtask

    task automatic test_back_pressure();
        exp_t e;
        tick();
        stb_data_valid[1] = 1'b1;
        stb_data[63:32]   = 32'hDEADBEEF;
        exp_q.push_back('{addr: 5'h15, data: 41'h00_DEAD_BEEF});
        tick();
        // valid stays high: the following edge must be back-pressured
        tick();
        stb_data[63:32] = 32'h0BADF00D;
        exp_q.push_back('{addr: 5'h15, data: 41'h00_0BAD_F00D});
        e = exp_q.pop_front();
        read_address = e.addr;
        @(negedge clk);
        n_total++;
        if (stb_data_ready[1] !== 1'b0) $display("FAIL bp_ready: got %b want 0", stb_data_ready[1]);
        else n_pass++;
        n_total++;
        if (read_valid !== 1'b1 || read_data !== e.data)
            $display("FAIL bp_hold: rv=%b rd=%h want 1 %h", read_valid, read_data, e.data);
        else n_pass++;
        n_total++;
        if (valid_any !== 1'b1 || valid_address !== 5'h15)
            $display("FAIL bp_advert: any=%b addr=%h want 1 15", valid_any, valid_address);
        else n_pass++;
        tick();
        read_ready = 1'b1;
        tick();
        read_ready = 1'b0;
        @(negedge clk);
        n_total++;
        if (stb_data_ready[1] !== 1'b1 || read_valid !== 1'b0)
            $display("FAIL bp_no_same_cycle_refill: ready=%b rv=%b want 1 0", stb_data_ready[1], read_valid);
        else n_pass++;
        tick();
        stb_data_valid[1] = 1'b0;
        e = exp_q.pop_front();
        @(negedge clk);
        n_total++;
        if (read_valid !== 1'b1 || read_data !== e.data || stb_data_ready[1] !== 1'b0)
            $display("FAIL bp_second_word: rv=%b rd=%h ready=%b want 1 %h 0", read_valid, read_data, stb_data_ready[1], e.data);
        else n_pass++;
        tick();
        read_ready = 1'b1;
        tick();
        read_ready = 1'b0;
        @(negedge clk);
        n_total++;
        if (read_valid !== 1'b0 || valid_any !== 1'b0)
            $display("FAIL bp_drain: rv=%b any=%b want 0 0", read_valid, valid_any);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        exp_t e;
        tick();
        dmi_valid           = 1'b1;
        dmi_data            = 41'h0_0ABC_DEF0;
        stb_status_valid[0] = 1'b1;
        stb_status[7:0]     = 8'hA5;
        stb_data_valid[1]   = 1'b1;
        stb_data[63:32]     = 32'h12345678;
        exp_q.push_back('{addr: 5'h11, data: 41'h0_0ABC_DEF0});
        exp_q.push_back('{addr: 5'h12, data: 41'h00_0000_00A5});
        exp_q.push_back('{addr: 5'h15, data: 41'h00_1234_5678});
        tick();
        dmi_valid = 1'b0;
        stb_status_valid = '0;
        stb_data_valid   = '0;
        read_address = 5'h05;
        @(negedge clk);
        n_total++;
        if (read_valid !== 1'b0 || read_data !== 41'h0)
            $display("FAIL unmapped_read: rv=%b rd=%h want 0 0", read_valid, read_data);
        else n_pass++;
        for (int n = 0; n < 3; n++) begin
            e = exp_q.pop_front();
            tick();
            read_address = e.addr;
            @(negedge clk);
            n_total++;
            if (valid_any !== 1'b1 || valid_address !== e.addr)
                $display("FAIL rr_advert_%0d: any=%b addr=%h want 1 %h", n, valid_any, valid_address, e.addr);
            else n_pass++;
            n_total++;
            if (read_valid !== 1'b1 || read_data !== e.data)
                $display("FAIL rr_read_%0d: rv=%b rd=%h want 1 %h", n, read_valid, read_data, e.data);
            else n_pass++;
            tick();
            read_ready = 1'b1;
            tick();
            read_ready = 1'b0;
        end
        @(negedge clk);
        n_total++;
        if (valid_any !== 1'b0 || valid_address !== 5'h0)
            $display("FAIL rr_idle: any=%b addr=%h want 0 00", valid_any, valid_address);
        else n_pass++;
    endtask

    task automatic test_occupancy();
        exp_t e;
        tick();
        dmi_valid         = 1'b1;
        dmi_data          = 41'h1_0000_0001;
        stb_data_valid[0] = 1'b1;
        stb_data[31:0]    = 32'h55AA55AA;
        exp_q.push_back('{addr: 5'h11, data: 41'h1_0000_0001});
        exp_q.push_back('{addr: 5'h13, data: 41'h00_55AA_55AA});
        tick();
        dmi_valid      = 1'b0;
        stb_data_valid = '0;
        read_address   = 5'h1F;
        @(negedge clk);
        n_total++;
`ifdef TAP_READ_INTC_OCC_EN
        if (read_valid !== 1'b1 || read_data !== 41'h005)
            $display("FAIL occ_read: rv=%b rd=%h want 1 005", read_valid, read_data);
        else n_pass++;
`else
        if (read_valid !== 1'b0 || read_data !== 41'h0)
            $display("FAIL occ_unmapped: rv=%b rd=%h want 0 0", read_valid, read_data);
        else n_pass++;
`endif
        tick();
        read_ready = 1'b1;
        tick();
        read_ready = 1'b0;
        @(negedge clk);
        n_total++;
        if (dmi_ready !== 1'b0 || stb_data_ready[0] !== 1'b0 || valid_any !== 1'b1)
            $display("FAIL occ_no_clear: dmi=%b stb0d=%b any=%b want 0 0 1", dmi_ready, stb_data_ready[0], valid_any);
        else n_pass++;
        for (int n = 0; n < 2; n++) begin
            e = exp_q.pop_front();
            tick();
            read_address = e.addr;
            @(negedge clk);
            n_total++;
            if (read_valid !== 1'b1 || read_data !== e.data || valid_address !== e.addr)
                $display("FAIL occ_drain_%0d: rv=%b rd=%h adv=%h want 1 %h %h", n, read_valid, read_data, valid_address, e.data, e.addr);
            else n_pass++;
            tick();
            read_ready = 1'b1;
            tick();
            read_ready = 1'b0;
        end
    endtask

    task automatic test_reset_mid_transfer();
        logic [4:0] addrs [3];
        addrs[0] = 5'h11;
        addrs[1] = 5'h12;
        addrs[2] = 5'h13;
        tick();
        dmi_valid           = 1'b1;
        dmi_data            = 41'h0_FFFF_0000;
        stb_status_valid[0] = 1'b1;
        stb_status[7:0]     = 8'h3C;
        stb_data_valid[0]   = 1'b1;
        stb_data[31:0]      = 32'hA5A5A5A5;
        exp_q.push_back('{addr: 5'h11, data: 41'h0_FFFF_0000});
        exp_q.push_back('{addr: 5'h12, data: 41'h00_0000_003C});
        exp_q.push_back('{addr: 5'h13, data: 41'h00_A5A5_A5A5});
        tick();
        dmi_valid        = 1'b0;
        stb_status_valid = '0;
        stb_data_valid   = '0;
        read_address     = 5'h11;
        read_ready       = 1'b1;
        #2;
        rst = 1'b1;
        // the reset discards every buffered word
        exp_q.delete();
        #1;
        n_total++;
        if ({read_valid, read_data, valid_any, valid_address} !== 48'h0)
            $display("FAIL midreset_outputs: rv=%b rd=%h any=%b addr=%h want all 0", read_valid, read_data, valid_any, valid_address);
        else n_pass++;
        n_total++;
        if ({dmi_ready, stb_status_ready, stb_data_ready} !== 5'b0)
            $display("FAIL midreset_ready: got %b want 00000", {dmi_ready, stb_status_ready, stb_data_ready});
        else n_pass++;
        tick();
        read_ready = 1'b0;
        rst = 1'b0;
        tick();
        @(negedge clk);
        n_total++;
        if ({dmi_ready, stb_status_ready, stb_data_ready} !== 5'b11111)
            $display("FAIL midreset_release_ready: got %b want 11111", {dmi_ready, stb_status_ready, stb_data_ready});
        else n_pass++;
        for (int n = 0; n < 3; n++) begin
            read_address = addrs[n];
            #1;
            n_total++;
            if (read_valid !== 1'b0 || read_data !== 41'h0)
                $display("FAIL midreset_stale_%h: rv=%b rd=%h want 0 0", addrs[n], read_valid, read_data);
            else n_pass++;
        end
    endtask

    initial begin
        rst              = 1'b1;
        read_address     = '0;
        read_ready       = 1'b0;
        dmi_valid        = 1'b0;
        dmi_data         = '0;
        stb_status_valid = '0;
        stb_status       = '0;
        stb_data_valid   = '0;
        stb_data         = '0;
        test_reset();
        test_dmi();
        test_back_pressure();
        test_round_robin();
        test_occupancy();
        test_reset_mid_transfer();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
